// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense controller.
//   state_t : dispense sequencer states
//   req_t   : one queued request {prod, coins[1:0]}
//   CHG_*   : change-unit codes carried in req_t.coins
// Helper functions: coins_dec (saturating decrement), max2 (constant max).
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MOTOR = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  typedef struct packed {
    logic       prod;
    logic [1:0] coins;
  } req_t;

  localparam logic [1:0] CHG_NONE = 2'd0;
  localparam logic [1:0] CHG_ONE  = 2'd1;
  localparam logic [1:0] CHG_TWO  = 2'd2;

  // Coin count never wraps below zero.
  function automatic logic [1:0] coins_dec(input logic [1:0] c);
    return (c == CHG_NONE) ? CHG_NONE : c - CHG_ONE;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// Request FIFO for the dispense controller: DEPTH entries of req_t.
// Pointers carry one extra bit so full and empty are distinct at wrap-around.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is ignored here (the parent flags the drop).
// Ports:
//   clk, rst   : clock, async active-high reset
//   push, din  : write request and data
//   pop, dout  : read request and head-of-queue data (valid when !empty)
//   full, empty: occupancy flags, derived from registered pointers
module vend_req_fifo
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  req_t din,
  input  logic pop,
  output req_t dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  req_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer between the vending FSM and the actuator pins.
// Every cycle with {out,change} != 0 queues one request; requests are served
// in order: product motor (handshaked by motor_done), then one hopper pulse
// per change unit. Upstream is never stalled; drops set the sticky overflow.
//
// Optional feature macro: VEND_MOTOR_TIMEOUT_EN
//   defined   : MOTOR gives up after MOTOR_TIMEOUT cycles, sets sticky fault,
//               and still pays the change.
//   undefined : MOTOR waits for motor_done indefinitely, fault is tied low.
//
// Ports:
//   clk, rst     : clock, async active-high reset
//   out          : vend strobe
//   change[1:0]  : change units owed with this strobe
//   motor_done   : product-drop sensor (synchronous level)
//   motor_en     : product motor drive
//   hopper_pulse : one pulse per change coin
//   busy         : queue non-empty or sequencer not idle
//   full         : queue holds FIFO_DEPTH requests
//   overflow     : sticky, a request was dropped
//   fault        : sticky motor timeout
//
// state | meaning
// IDLE  | waiting; pops the queue head when one is present
// LOAD  | popped record held; choose motor, hopper or done
// MOTOR | motor_en high until motor_done (or timeout)
// PULSE | hopper_pulse high for PULSE_LEN cycles
// GAP   | hopper low for GAP_LEN cycles between coins
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned PULSE_LEN     = 4,
  parameter int unsigned GAP_LEN       = 4,
  parameter int unsigned MOTOR_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       out,
  input  logic [1:0] change,
  input  logic       motor_done,
  output logic       motor_en,
  output logic       hopper_pulse,
  output logic       busy,
  output logic       full,
  output logic       overflow,
  output logic       fault
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (PULSE_LEN < 1 || GAP_LEN < 1 || MOTOR_TIMEOUT < 1) begin : g_chk_len
    $error("PULSE_LEN, GAP_LEN and MOTOR_TIMEOUT must be at least 1");
  end

  // One shared down-counter times pulse, gap and (optionally) the motor.
`ifdef VEND_MOTOR_TIMEOUT_EN
  localparam int unsigned TMR_MAX = max2(max2(PULSE_LEN, GAP_LEN), MOTOR_TIMEOUT);
`else
  localparam int unsigned TMR_MAX = max2(PULSE_LEN, GAP_LEN);
`endif
  localparam int unsigned TW = $clog2(TMR_MAX + 1);

  localparam logic [TW-1:0] TMR_PULSE = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] TMR_GAP   = TW'(GAP_LEN - 1);
`ifdef VEND_MOTOR_TIMEOUT_EN
  localparam logic [TW-1:0] TMR_MOTOR = TW'(MOTOR_TIMEOUT - 1);
`endif

  state_t        state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [1:0]    coins, coins_nxt;
  logic          prod, prod_nxt;
  logic          push;
  logic          pop;
  logic          motor_exit;
  logic          fifo_empty;
  req_t          fifo_din;
  req_t          fifo_dout;
  logic          ovf_q;

  assign push     = out || (change != CHG_NONE);
  assign fifo_din = '{prod: out, coins: change};

  vend_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (fifo_empty)
  );

`ifdef VEND_MOTOR_TIMEOUT_EN
  logic fault_set;
  logic fault_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      tmr   <= '0;
      coins <= CHG_NONE;
      prod  <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      coins <= coins_nxt;
      prod  <= prod_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tmr_nxt    = tmr;
    coins_nxt  = coins;
    prod_nxt   = prod;
    pop        = 1'b0;
    motor_exit = 1'b0;
`ifdef VEND_MOTOR_TIMEOUT_EN
    fault_set  = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          prod_nxt  = fifo_dout.prod;
          coins_nxt = fifo_dout.coins;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (prod) begin
          state_nxt = ST_MOTOR;
`ifdef VEND_MOTOR_TIMEOUT_EN
          tmr_nxt   = TMR_MOTOR;
`endif
        end else if (coins != CHG_NONE) begin
          state_nxt = ST_PULSE;
          tmr_nxt   = TMR_PULSE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_MOTOR: begin
        motor_exit = motor_done;
`ifdef VEND_MOTOR_TIMEOUT_EN
        if (!motor_done) begin
          if (tmr == '0) begin
            motor_exit = 1'b1;
            fault_set  = 1'b1;
          end else begin
            tmr_nxt = tmr - TW'(1);
          end
        end
`endif
        // Change is owed even if the product drop timed out.
        if (motor_exit) begin
          if (coins != CHG_NONE) begin
            state_nxt = ST_PULSE;
            tmr_nxt   = TMR_PULSE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_PULSE: begin
        if (tmr == '0) begin
          state_nxt = ST_GAP;
          tmr_nxt   = TMR_GAP;
          coins_nxt = coins_dec(coins);
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      ST_GAP: begin
        if (tmr == '0) begin
          if (coins != CHG_NONE) begin
            state_nxt = ST_PULSE;
            tmr_nxt   = TMR_PULSE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A push into a full queue survives only if the sequencer pops this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (push && full && !pop) begin
      ovf_q <= 1'b1;
    end
  end

`ifdef VEND_MOTOR_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // Actuators decode straight from the state register so reset clears them at once.
  assign motor_en     = (state == ST_MOTOR);
  assign hopper_pulse = (state == ST_PULSE);
  assign busy         = !fifo_empty || (state != ST_IDLE);
  assign overflow     = ovf_q;

endmodule
